// File: rtl/bounce_pkg.sv
// Shared definitions for the bounce monitor: tracker state encoding, event kind
// constants and the sample width.
package bounce_pkg;

    localparam int unsigned SAMPLE_W = 32;

    // Tracker state; the numeric value is exported directly on the dir port.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FLAT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_e;

    localparam logic PEAK   = 1'b0;
    localparam logic VALLEY = 1'b1;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO holding detected events.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write request and payload
//   pop           read request; ignored while empty
//   rdata         head entry (don't-care while empty)
//   full, empty   occupancy flags
// A push while full is accepted only when a pop happens on the same edge.
module event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bounce_monitor.sv
// Tracks the direction of an accepted sample stream and reports turning points.
// An UP->DOWN turn emits a peak, a DOWN->UP turn emits a valley; the event value
// is the sample before the turn and the period is the number of accepted samples
// since the previous event. Events are queued in a FIFO for a ready/valid consumer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   sample_in, sample_en          signed sample and its accept strobe
//   evt_valid, evt_ready          FIFO head handshake
//   evt_kind, evt_value, evt_period  head event fields
//   peak_count, valley_count      wrapping detection counters (include drops)
//   dir                           current tracker state
//   overflow                      sticky: an event was dropped on a full FIFO
module bounce_monitor
    import bounce_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_en,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic                       evt_kind,
    output logic signed [SAMPLE_W-1:0] evt_value,
    output logic [PERIOD_W-1:0]        evt_period,
    output logic [PERIOD_W-1:0]        peak_count,
    output logic [PERIOD_W-1:0]        valley_count,
    output logic [1:0]                 dir,
    output logic                       overflow
);

    localparam int unsigned EVT_W = 1 + SAMPLE_W + PERIOD_W;

    state_e                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic [PERIOD_W-1:0]        smp_cnt_q, smp_cnt_d;
    logic [PERIOD_W-1:0]        peak_cnt_q, peak_cnt_d;
    logic [PERIOD_W-1:0]        valley_cnt_q, valley_cnt_d;
    logic                       overflow_q, overflow_d;

    logic                       is_peak, is_valley;
    logic                       evt_push, evt_pop;
    logic [PERIOD_W-1:0]        cnt_inc;
    logic [EVT_W-1:0]           evt_wdata, evt_rdata;
    logic                       fifo_full, fifo_empty;

    assign evt_push  = is_peak || is_valley;
    assign evt_valid = !fifo_empty;
    assign evt_pop   = evt_valid && evt_ready;
    assign evt_wdata = {(is_valley ? VALLEY : PEAK), prev_q, cnt_inc};

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        smp_cnt_d    = smp_cnt_q;
        peak_cnt_d   = peak_cnt_q;
        valley_cnt_d = valley_cnt_q;
        is_peak      = 1'b0;
        is_valley    = 1'b0;
        // Saturating increment; also the reported period on an event sample.
        cnt_inc      = (&smp_cnt_q) ? smp_cnt_q : smp_cnt_q + PERIOD_W'(1);

        if (sample_en) begin
            prev_d    = sample_in;
            smp_cnt_d = cnt_inc;
            unique case (state_q)
                EMPTY: state_d = FLAT;
                FLAT: begin
                    if (sample_in > prev_q) begin
                        state_d = UP;
                    end else if (sample_in < prev_q) begin
                        state_d = DOWN;
                    end
                end
                UP: begin
                    if (sample_in < prev_q) begin
                        state_d = DOWN;
                        is_peak = 1'b1;
                    end
                end
                DOWN: begin
                    if (sample_in > prev_q) begin
                        state_d   = UP;
                        is_valley = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (is_peak || is_valley) begin
                smp_cnt_d = '0;
            end
        end

        if (is_peak) begin
            peak_cnt_d = peak_cnt_q + PERIOD_W'(1);
        end
        if (is_valley) begin
            valley_cnt_d = valley_cnt_q + PERIOD_W'(1);
        end
        // A pop on the same edge frees a slot, so only full-without-pop drops.
        overflow_d = overflow_q || (evt_push && fifo_full && !evt_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            prev_q       <= '0;
            smp_cnt_q    <= '0;
            peak_cnt_q   <= '0;
            valley_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            smp_cnt_q    <= smp_cnt_d;
            peak_cnt_q   <= peak_cnt_d;
            valley_cnt_q <= valley_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_event_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_push),
        .pop   (evt_pop),
        .wdata (evt_wdata),
        .rdata (evt_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_kind     = evt_rdata[EVT_W-1];
    assign evt_value    = evt_rdata[EVT_W-2 -: SAMPLE_W];
    assign evt_period   = evt_rdata[PERIOD_W-1:0];
    assign peak_count   = peak_cnt_q;
    assign valley_count = valley_cnt_q;
    assign dir          = state_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_bounce_monitor.sv
// Self-checking bench for bounce_monitor: directed scenarios plus random
// stimulus, compared every cycle against a trend/queue reference model.
module tb_bounce_monitor;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 4;   // narrow so saturation and wrap are reachable
    localparam int MAXC = (1 << PW) - 1;
    localparam int MODC = (1 << PW);

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] sample_in;
    logic               sample_en;
    logic               evt_valid;
    logic               evt_ready;
    logic               evt_kind;
    logic signed [31:0] evt_value;
    logic [PW-1:0]      evt_period;
    logic [PW-1:0]      peak_count;
    logic [PW-1:0]      valley_count;
    logic [1:0]         dir;
    logic               overflow;

    int n_cmp = 0;
    int n_err = 0;

    bounce_monitor #(
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_en    (sample_en),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_kind     (evt_kind),
        .evt_value    (evt_value),
        .evt_period   (evt_period),
        .peak_count   (peak_count),
        .valley_count (valley_count),
        .dir          (dir),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: "seen" = a first sample exists, trend = -1/0/+1.
    typedef struct {
        bit                 kind;
        logic signed [31:0] value;
        int                 period;
    } evt_t;

    evt_t               m_q[$];
    bit                 m_seen;
    int                 m_trend;
    logic signed [31:0] m_prev;
    int                 m_cnt;
    int                 m_peaks;
    int                 m_valleys;
    bit                 m_ovf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_dir();
        if (!m_seen) return 0;
        if (m_trend == 0) return 1;
        return (m_trend > 0) ? 2 : 3;
    endfunction

    task automatic model_update(input bit r, input bit en, input logic signed [31:0] s,
                                input bit rdy);
        evt_t e;
        bit   have;
        bit   pop;
        int   sz;
        if (r) begin
            m_q.delete();
            m_seen = 0; m_trend = 0; m_prev = 0; m_cnt = 0;
            m_peaks = 0; m_valleys = 0; m_ovf = 0;
            return;
        end
        have = 0;
        sz   = m_q.size();
        pop  = (sz > 0) && rdy;
        if (en) begin
            m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
            if (!m_seen) begin
                m_seen = 1;
            end else if (s > m_prev) begin
                if (m_trend < 0) begin have = 1; e.kind = 1; end
                m_trend = 1;
            end else if (s < m_prev) begin
                if (m_trend > 0) begin have = 1; e.kind = 0; end
                m_trend = -1;
            end
            if (have) begin
                e.value  = m_prev;
                e.period = m_cnt;
                m_cnt    = 0;
                if (e.kind) m_valleys = (m_valleys + 1) % MODC;
                else        m_peaks   = (m_peaks + 1) % MODC;
            end
            m_prev = s;
        end
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (sz < DEPTH || pop) m_q.push_back(e);
            else                   m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        check_eq("evt_valid", evt_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_eq("evt_kind", evt_kind, m_q[0].kind);
            check_eq("evt_value", evt_value, m_q[0].value);
            check_eq("evt_period", evt_period, m_q[0].period);
        end
        check_eq("peak_count", peak_count, m_peaks);
        check_eq("valley_count", valley_count, m_valleys);
        check_eq("dir", dir, exp_dir());
        check_eq("overflow", overflow, m_ovf);
    endtask

    // Drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input bit r, input bit en, input logic signed [31:0] s, input bit rdy);
        rst = r; sample_en = en; sample_in = s; evt_ready = rdy;
        @(posedge clk);
        model_update(r, en, s, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic feed(input int vals[], input bit rdy);
        foreach (vals[i]) step(0, 1, vals[i], rdy);
    endtask

    initial begin
        int n;
        int exp_vals[4];
        rst = 1; sample_en = 0; sample_in = 0; evt_ready = 0;
        model_update(1, 0, 0, 0);
        @(negedge clk);

        // Reset held two cycles
        step(1, 1, 55, 1);
        step(1, 1, 66, 1);
        check_eq("rst_dir", dir, 0);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_peaks", peak_count, 0);
        check_eq("rst_valleys", valley_count, 0);
        check_eq("rst_ovf", overflow, 0);

        // Peak
        feed('{0, 30, 60, 90, 120, 120}, 1);
        check_eq("peak_pre_valid", evt_valid, 0);
        step(0, 1, 90, 1);
        check_eq("peak_valid", evt_valid, 1);
        check_eq("peak_kind", evt_kind, 0);
        check_eq("peak_value", evt_value, 120);
        check_eq("peak_period", evt_period, 7);
        check_eq("peak_count1", peak_count, 1);
        check_eq("peak_dir", dir, 3);

        // Valley
        step(0, 1, 60, 1);
        check_eq("peak_one_cycle", evt_valid, 0);
        feed('{30, 0, 0, 30}, 1);
        check_eq("valley_valid", evt_valid, 1);
        check_eq("valley_kind", evt_kind, 1);
        check_eq("valley_value", evt_value, 0);
        check_eq("valley_period", evt_period, 5);
        check_eq("valley_count1", valley_count, 1);
        check_eq("valley_dir", dir, 2);
        step(0, 0, 0, 1);

        // Overflow: 5 events, 4 slots, consumer stalled
        step(1, 0, 0, 0);
        feed('{0, 10, 5, 20, 0, 30, -10}, 0);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_total", peak_count + valley_count, 5);
        exp_vals = '{10, 5, 20, 0};
        n = 0;
        while (evt_valid && n < 8) begin
            if (n < 4) check_eq("ovf_drain_val", evt_value, exp_vals[n]);
            step(0, 0, 0, 1);
            n++;
        end
        check_eq("ovf_drain_cnt", n, 4);

        // Full FIFO with simultaneous push and pop
        step(1, 0, 0, 0);
        feed('{0, 10, 5, 20, 0, 30}, 0);
        step(0, 1, -10, 1);
        check_eq("fullpp_ovf", overflow, 0);
        n = 0;
        while (evt_valid && n < 8) begin
            step(0, 0, 0, 1);
            n++;
        end
        check_eq("fullpp_occ", n, 4);
        check_eq("fullpp_ovf2", overflow, 0);

        // Period saturation on a long plateau
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 5, 1);
        step(0, 1, 0, 1);
        check_eq("sat_period", evt_period, MAXC);
        check_eq("sat_value", evt_value, 5);

        // Mid-stream reset with 2 queued events in UP
        step(1, 0, 0, 0);
        feed('{0, 10, 5, 20}, 0);
        check_eq("mid_dir_up", dir, 2);
        step(1, 1, 3, 1);
        check_eq("mid_valid", evt_valid, 0);
        check_eq("mid_dir", dir, 0);
        step(0, 1, 7, 1);
        check_eq("mid_flat", dir, 1);
        check_eq("mid_valid2", evt_valid, 0);

        // Random traffic, including signed extremes and bursts of back-pressure
        for (int i = 0; i < 3000; i++) begin
            logic signed [31:0] s;
            bit r, en, rdy;
            int pick;
            pick = $urandom_range(0, 9);
            if (pick == 0)      s = 32'sh7fffffff;
            else if (pick == 1) s = 32'sh80000000;
            else                s = $signed($urandom_range(0, 6)) - 3;
            r   = ($urandom_range(0, 249) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ((i / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            step(r, en, s, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
